// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, one bit per cycle, then one cycle to apply sign and flags.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fin_q, fin_d;         // all steps done; next RUN cycle applies sign
    logic             is_mult_q, is_mult_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] b_mag_q, b_mag_d;
    logic [WIDTH-1:0] hi_q, hi_d;           // mult: product high half / div: partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;           // mult: multiplier shifting out / div: dividend -> quotient
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;

    logic               start;
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] mul_signed;
    logic [WIDTH-1:0]   quot_signed;

    assign start       = ctrl_MULT | ctrl_DIV;
    assign mul_addend  = lo_q[0] ? b_mag_q : '0;
    assign mul_sum     = {1'b0, hi_q} + {1'b0, mul_addend};
    assign div_shift   = {hi_q, lo_q[WIDTH-1]};
    assign div_diff    = div_shift - {1'b0, b_mag_q};
    assign mul_signed  = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign quot_signed = neg_q ? -lo_q : lo_q;

    // NOTE: every variable gets its hold/default value first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fin_d     = fin_q;
        is_mult_d = is_mult_q;
        neg_d     = neg_q;
        b_mag_d   = b_mag_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        result_d  = result_q;
        exc_d     = exc_q;
        rdy_d     = 1'b0;
        busy_d    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    fin_d     = 1'b0;
                    is_mult_d = ctrl_MULT;  // multiply wins a simultaneous start
                    neg_d     = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    lo_d      = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
                    b_mag_d   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
                    hi_d      = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (fin_q) begin
                    state_d = DONE;
                    rdy_d   = 1'b1;
                    fin_d   = 1'b0;
                    if (is_mult_q) begin
                        result_d = mul_signed[WIDTH-1:0];
                        exc_d    = mul_signed[2*WIDTH-1:WIDTH] != {WIDTH{mul_signed[WIDTH-1]}};
                    end else if (b_mag_q == '0) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else begin
                        // Only -2^(W-1) / -1 yields a positive quotient with the top bit set.
                        result_d = quot_signed;
                        exc_d    = ~neg_q & lo_q[WIDTH-1];
                    end
                end else begin
                    busy_d = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        fin_d = 1'b1;
                        cnt_d = '0;
                    end
                    if (is_mult_q) begin
                        hi_d = mul_sum[WIDTH:1];
                        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                    end else begin
                        hi_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fin_q     <= 1'b0;
            is_mult_q <= 1'b0;
            neg_q     <= 1'b0;
            b_mag_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fin_q     <= fin_d;
            is_mult_q <= is_mult_d;
            neg_q     <= neg_d;
            b_mag_q   <= b_mag_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule
